// File: rtl/pll_reset_seq_pkg.sv
// rtl/pll_reset_seq_pkg.sv - shared types and helpers for the PLL reset sequencer
// Purpose: state encoding, event-counter width, counter-width and saturating-increment helpers.
// Ports: none (package).
package pll_reset_seq_pkg;

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam int COUNT_W = 8;

  // Width of the single shared phase counter: enough bits for the longest phase plus one.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

  // Event counters stick at all-ones instead of wrapping.
  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (v == {COUNT_W{1'b1}}) ? v : v + COUNT_W'(1);
  endfunction

endpackage

// File: rtl/sync_bit.sv
// rtl/sync_bit.sv - multi-flop single-bit synchronizer
// Purpose: brings an asynchronous level into the clk domain through STAGES flops.
// Ports:
//   clk   in  destination clock
//   rst_n in  asynchronous active-low reset, clears all stages to 0
//   d     in  asynchronous input level
//   q     out synchronized level
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr <= '0;
    else        sr <= {sr[STAGES-2:0], d};
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/pll_reset_seq.sv
// rtl/pll_reset_seq.sv - PLL lock supervisor and core reset sequencer
// Purpose: pulses the PLL reset, waits for lock, requires lock to stay stable for a
// programmable time before releasing the core reset, and re-holds the core in reset
// on lock loss. Optional macro PLL_RESET_SEQ_TIMEOUT_EN enables the lock-wait timeout
// retry and the retry counter; without it retry_count is tied to 0.
// Ports:
//   clk_74a        in  reference clock
//   reset_n        in  asynchronous active-low reset
//   pll_locked     in  PLL lock, asynchronous to clk_74a
//   soft_reset_req in  single-cycle request to rerun the whole sequence
//   pll_rst        out active-high PLL reset
//   core_reset_n   out active-low core reset, high only in RUN
//   ready          out high in RUN
//   relock_count   out lock losses seen in RUN, saturating
//   retry_count    out timeout-driven PLL reset retries, saturating
module pll_reset_seq
  import pll_reset_seq_pkg::*;
#(
  parameter int SYNC_STAGES         = 2,
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 1048576
) (
  input  logic               clk_74a,
  input  logic               reset_n,
  input  logic               pll_locked,
  input  logic               soft_reset_req,
  output logic               pll_rst,
  output logic               core_reset_n,
  output logic               ready,
  output logic [COUNT_W-1:0] relock_count,
  output logic [COUNT_W-1:0] retry_count
);

  localparam int CW = cnt_width(PLL_RST_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES);
  localparam logic [CW-1:0] RST_LAST    = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE_CYCLES - 1);
`ifdef PLL_RESET_SEQ_TIMEOUT_EN
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
`endif

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [COUNT_W-1:0] relock_q, relock_d;
  logic [COUNT_W-1:0] retry_q, retry_d;
  logic               locked_s;

  sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk   (clk_74a),
    .rst_n (reset_n),
    .d     (pll_locked),
    .q     (locked_s)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    relock_d = relock_q;
    retry_d  = retry_q;

    case (state_q)
      PLL_RST: begin
        if (cnt_q == RST_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT_LOCK: begin
        if (locked_s) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else begin
`ifdef PLL_RESET_SEQ_TIMEOUT_EN
          if (cnt_q == TIMEOUT_LAST) begin
            state_d = PLL_RST;
            cnt_d   = '0;
            retry_d = sat_inc(retry_q);
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
`else
          // Without a timeout the wait is unbounded; the counter simply idles.
          cnt_d = cnt_q;
`endif
        end
      end
      STABLE: begin
        // A dropout restarts the stability window from WAIT_LOCK; it is not a relock event.
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_d  = WAIT_LOCK;
          cnt_d    = '0;
          relock_d = sat_inc(relock_q);
        end
      end
      default: begin
        state_d = PLL_RST;
        cnt_d   = '0;
      end
    endcase

    // Soft reset wins over everything, including any event counted above this cycle.
    if (soft_reset_req) begin
      state_d  = PLL_RST;
      cnt_d    = '0;
      relock_d = relock_q;
      retry_d  = retry_q;
    end
  end

  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= PLL_RST;
      cnt_q        <= '0;
      relock_q     <= '0;
      pll_rst      <= 1'b1;
      core_reset_n <= 1'b0;
      ready        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      relock_q     <= relock_d;
      pll_rst      <= (state_d == PLL_RST);
      core_reset_n <= (state_d == RUN);
      ready        <= (state_d == RUN);
    end
  end

`ifdef PLL_RESET_SEQ_TIMEOUT_EN
  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) retry_q <= '0;
    else          retry_q <= retry_d;
  end
`else
  assign retry_q = '0;
`endif

  assign relock_count = relock_q;
  assign retry_count  = retry_q;

endmodule
